// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT output-side streaming path.
//   FFT_DW_OUT : bits per output sample (signed two's complement)
//   FFT_NPTS   : points per frame
//   FFT_LANES  : samples carried per output beat
//   FFT_BEATS  : beats per frame (FFT_NPTS / FFT_LANES)
//   stream_state_t : control state of the output streamer
package fft_pkg;

  localparam int FFT_DW_OUT = 13;
  localparam int FFT_NPTS   = 512;
  localparam int FFT_LANES  = 16;
  localparam int FFT_BEATS  = FFT_NPTS / FFT_LANES;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: capture registers for one full I/Q frame plus the beat-slice
// mux that presents LANES consecutive points of each rail.
//   clk, rstn             : clock, synchronous active-low reset (clears buffers)
//   load                  : capture din_R_frame/din_Q_frame this cycle
//   din_R_frame/_Q_frame  : packed frames, point p at [p*DATA_WIDTH +: DATA_WIDTH]
//   beat                  : registered beat index selecting the output slice
//   out_R/out_Q           : LANES samples, lane l = point beat*LANES+l
module fft_frame_buf #(
  parameter int DATA_WIDTH = 13,
  parameter int NUM_PTS    = 512,
  parameter int LANES      = 16,
  parameter int BEAT_W     = 5
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          load,
  input  logic [NUM_PTS*DATA_WIDTH-1:0] din_R_frame,
  input  logic [NUM_PTS*DATA_WIDTH-1:0] din_Q_frame,
  input  logic [BEAT_W-1:0]             beat,
  output logic [LANES*DATA_WIDTH-1:0]   out_R,
  output logic [LANES*DATA_WIDTH-1:0]   out_Q
);

  localparam int FRAME_W = NUM_PTS * DATA_WIDTH;
  localparam int SLICE_W = LANES * DATA_WIDTH;

  logic [FRAME_W-1:0] buf_R;
  logic [FRAME_W-1:0] buf_Q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_R <= '0;
      buf_Q <= '0;
    end else if (load) begin
      buf_R <= din_R_frame;
      buf_Q <= din_Q_frame;
    end
  end

  // Slice select depends only on registers (buffers and beat), so the beat
  // outputs carry no combinational path from any input port.
  assign out_R = buf_R[32'(beat) * SLICE_W +: SLICE_W];
  assign out_Q = buf_Q[32'(beat) * SLICE_W +: SLICE_W];

endmodule

// File: rtl/fft_out_streamer.sv
// fft_out_streamer: drains reordered 512-point I/Q frames from the FFT core
// and streams each as BEATS beats of LANES samples.
//   clk, rstn          : clock, synchronous active-low reset
//   done               : one-cycle frame-ready strobe from the FFT core
//   din_R_frame/_Q     : full frames, captured when done is honoured
//   out_valid/out_ready: beat handshake
//   out_R/out_Q        : beat data, lane l = point beat*LANES+l
//   out_sop/out_eop    : first / last beat markers
//   busy               : a frame is held (mirrors the STREAM state)
//   overrun            : sticky, a done arrived while a frame was still held
//   frame_cnt          : frames fully delivered, wraps at 8 bits
//
// Handshake: a beat transfers on every rising edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high and out_R, out_Q,
// out_sop and out_eop stay unchanged until that transfer; out_ready may be
// driven freely and never influences the outputs combinationally.
module fft_out_streamer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DW_OUT,
  parameter int NUM_PTS    = FFT_NPTS,
  parameter int LANES      = FFT_LANES
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          done,
  input  logic [NUM_PTS*DATA_WIDTH-1:0] din_R_frame,
  input  logic [NUM_PTS*DATA_WIDTH-1:0] din_Q_frame,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_R,
  output logic [LANES*DATA_WIDTH-1:0]   out_Q,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          busy,
  output logic                          overrun,
  output logic [7:0]                    frame_cnt
);

  localparam int BEATS  = NUM_PTS / LANES;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  stream_state_t     state, state_nx;
  logic [BEAT_W-1:0] beat, beat_nx;
  logic [7:0]        frame_cnt_nx;
  logic              overrun_nx;
  logic              load;
  logic              accept;
  logic              last_accept;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      beat      <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      beat      <= beat_nx;
      frame_cnt <= frame_cnt_nx;
      overrun   <= overrun_nx;
    end
  end

  assign accept      = out_valid & out_ready;
  assign last_accept = accept & (beat == LAST_BEAT);

  always_comb begin
    state_nx     = state;
    beat_nx      = beat;
    frame_cnt_nx = frame_cnt;
    overrun_nx   = overrun;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (done) begin
          load     = 1'b1;
          beat_nx  = '0;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        if (last_accept) begin
          frame_cnt_nx = frame_cnt + 8'd1;
          // The buffer is free exactly on the last accept, so a done here
          // refills it and streaming continues without a bubble.
          if (done) begin
            load    = 1'b1;
            beat_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          if (accept) begin
            beat_nx = beat + BEAT_W'(1);
          end
          // Any other done finds the buffer occupied: drop that frame.
          if (done) begin
            overrun_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  fft_frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_PTS    (NUM_PTS),
    .LANES      (LANES),
    .BEAT_W     (BEAT_W)
  ) u_frame_buf (
    .clk         (clk),
    .rstn        (rstn),
    .load        (load),
    .din_R_frame (din_R_frame),
    .din_Q_frame (din_Q_frame),
    .beat        (beat),
    .out_R       (out_R),
    .out_Q       (out_Q)
  );

  assign out_valid = (state == STREAM);
  assign busy      = out_valid;
  assign out_sop   = out_valid & (beat == '0);
  assign out_eop   = out_valid & (beat == LAST_BEAT);

endmodule
